snespad_events: RTL and testbench

- Sits directly downstream of the SNES pad reader and consumes its 16-bit button word plus a once-per-poll valid strobe.
- Debounces the word by requiring STABLE_CNT consecutive identical polls before accepting it.
- Converts each accepted change into per-button press/release events and buffers them in a small FIFO with a valid/ready output, for the UART/console logic.

---
 rtl/snespad_pkg.sv | 27 ++
 rtl/snespad_evfifo.sv | 51 +++++
 rtl/snespad_events.sv | 98 +++++++++
 tb/tb_snespad_events.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/snespad_pkg.sv
// Shared constants for the SNES pad event path: button bit positions and
// the layout of a press/release event word.
package snespad_pkg;

   localparam int unsigned BTN_B      = 0;
   localparam int unsigned BTN_Y      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;
   localparam int unsigned BTN_A      = 8;
   localparam int unsigned BTN_X      = 9;
   localparam int unsigned BTN_L      = 10;
   localparam int unsigned BTN_R      = 11;

   localparam int unsigned EV_W       = 5;
   localparam int unsigned EV_LVL_BIT = 4;

   typedef logic [EV_W-1:0] ev_t;

   function automatic ev_t make_ev(input logic lvl, input logic [3:0] idx);
      return {lvl, idx};
   endfunction

endpackage

// File: rtl/snespad_evfifo.sv
// First-word-fall-through event FIFO; head entry is presented whenever the FIFO
// is non-empty. Depth must be a power of two so the pointers wrap naturally.
module snespad_evfifo #(
   parameter int unsigned Depth = 8,
   parameter int unsigned Width = 5
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [Width-1:0]           push_data_i,
   input  logic                       pop_i,
   output logic [Width-1:0]           pop_data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(Depth):0]     count_o
);

   localparam int unsigned AW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full_o     = (count_q == (AW+1)'(Depth));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign pop_data_o = mem_q[rd_ptr_q];

   // A pop frees the slot a simultaneous push lands in, so push is legal when full.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      end
   end

endmodule

// File: rtl/snespad_events.sv
// Debounces the SNES pad button word and turns each accepted change into
// per-button press/release events queued in a FIFO.
module snespad_events
   import snespad_pkg::*;
#(
   parameter int unsigned STABLE_CNT = 3,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [15:0]                   vdata_i,
   input  logic                          vvalid_i,
   output logic [15:0]                   btn_o,
   output logic                          ev_valid_o,
   input  logic                          ev_ready_i,
   output logic [EV_W-1:0]               ev_data_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o,
   output logic                          overflow_o,
   input  logic                          ov_clr_i
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;
   localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);

   logic [15:0] cand_q, cand_d, btn_q, pending_q;
   logic [3:0]  cnt_q, cnt_d, idx_q;
   logic [0:0]  state_q;
   logic        ov_q, commit, push, full, empty, drop;
   ev_t         push_data;

   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (vvalid_i) begin
         if (vdata_i != cand_q) begin
            cand_d = vdata_i;
            cnt_d  = 4'd1;
         end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   // Evaluated on the updated debouncer state, so a request held over a scan
   // commits on the first idle cycle without any extra bookkeeping.
   assign commit    = (state_q == ST_IDLE) && (cnt_d >= CNT_MAX) && (cand_d != btn_q);
   assign push      = (state_q == ST_SCAN) && pending_q[idx_q];
   assign push_data = make_ev(btn_q[idx_q], idx_q);
   // Full implies non-empty, so a ready consumer always frees a slot.
   assign drop      = push && full && !ev_ready_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cand_q    <= '0;
         cnt_q     <= '0;
         btn_q     <= '0;
         pending_q <= '0;
         idx_q     <= '0;
         state_q   <= ST_IDLE;
         ov_q      <= 1'b0;
      end else begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         if (commit) begin
            pending_q <= cand_d ^ btn_q;
            btn_q     <= cand_d;
            idx_q     <= '0;
            state_q   <= ST_SCAN;
         end else if (state_q == ST_SCAN) begin
            idx_q <= idx_q + 4'd1;
            if (idx_q == 4'd15) state_q <= ST_IDLE;
         end
         if (drop)          ov_q <= 1'b1;
         else if (ov_clr_i) ov_q <= 1'b0;
      end
   end

   snespad_evfifo #(
      .Depth (FIFO_DEPTH),
      .Width (EV_W)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_i),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (ev_ready_i),
      .pop_data_o  (ev_data_o),
      .full_o      (full),
      .empty_o     (empty),
      .count_o     (count_o)
   );

   assign btn_o      = btn_q;
   assign ev_valid_o = !empty;
   assign overflow_o = ov_q;

endmodule

// File: tb/tb_snespad_events.sv
// Directed bench for snespad_events: debounce, event ordering, backpressure.
module tb_snespad_events;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] vdata = '0;
   logic        vvalid = 1'b0;
   logic [15:0] btn;
   logic        ev_valid;
   logic        ev_ready = 1'b0;
   logic [4:0]  ev_data;
   logic [3:0]  count;
   logic        overflow;
   logic        ov_clr = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   logic [4:0] got[$];

   always #5 clk = ~clk;

   snespad_events #(
      .STABLE_CNT (3),
      .FIFO_DEPTH (8)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .vdata_i    (vdata),
      .vvalid_i   (vvalid),
      .btn_o      (btn),
      .ev_valid_o (ev_valid),
      .ev_ready_i (ev_ready),
      .ev_data_o  (ev_data),
      .count_o    (count),
      .overflow_o (overflow),
      .ov_clr_i   (ov_clr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      ev_ready = 1'b0;
      vvalid = 1'b0;
      ov_clr = 1'b0;
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic poll(input logic [15:0] v);
      vdata = v;
      vvalid = 1'b1;
      tick();
      vvalid = 1'b0;
   endtask

   // Three identical polls; returns right after the edge that samples the third.
   task automatic poll3(input logic [15:0] v, input int gap);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) repeat (gap) tick();
         poll(v);
      end
   endtask

   task automatic run_collect(input int n);
      ev_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (ev_valid) got.push_back(ev_data);
         tick();
      end
      ev_ready = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (btn !== 16'h0) begin n_err++; $display("FAIL reset_btn: got %h want 0000", btn); end
      n_cmp++; if (ev_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin
         n_err++; $display("FAIL reset_outs: valid=%b count=%0d ov=%b want 0/0/0", ev_valid, count, overflow);
      end
      poll3(16'h0001, 2);
      tick();
      n_cmp++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL reset_prescan: valid=%b want 1", ev_valid); end
      rst = 1'b0;
      #1;
      n_cmp++; if (btn !== 16'h0 || ev_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin
         n_err++;
         $display("FAIL reset_midscan: btn=%h valid=%b count=%0d ov=%b want 0", btn, ev_valid, count, overflow);
      end
      #1 rst = 1'b1;
      tick();
      got.delete();
      run_collect(30);
      n_cmp++; if (got.size() != 0) begin n_err++; $display("FAIL reset_noevents: got %0d events want 0", got.size()); end
   endtask

   task automatic test_accept();
      do_reset();
      poll3(16'h0100, 9);
      n_cmp++; if (btn !== 16'h0100) begin n_err++; $display("FAIL accept_btn: got %h want 0100", btn); end
      repeat (8) tick();
      n_cmp++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL accept_early: valid=%b want 0", ev_valid); end
      tick();
      n_cmp++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL accept_latency: valid=%b want 1", ev_valid); end
      repeat (10) tick();
      n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL accept_count: got %0d want 1", count); end
      n_cmp++; if (ev_data !== 5'h18) begin n_err++; $display("FAIL accept_data: got %h want 18", ev_data); end
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
      n_cmp++; if (count !== 4'd0 || ev_valid !== 1'b0) begin
         n_err++; $display("FAIL accept_pop: count=%0d valid=%b want 0/0", count, ev_valid);
      end
   endtask

   task automatic test_reject();
      logic [15:0] seq [5];
      seq = '{16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0100};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         poll(seq[i]);
         repeat (4) tick();
      end
      repeat (20) tick();
      n_cmp++; if (btn !== 16'h0) begin n_err++; $display("FAIL reject_btn: got %h want 0000", btn); end
      n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reject_count: got %0d want 0", count); end
   endtask

   task automatic test_multibit();
      logic [4:0] exp [4];
      exp = '{5'h00, 5'h03, 5'h14, 5'h17};
      do_reset();
      poll3(16'h0009, 3);
      got.delete();
      run_collect(25);
      n_cmp++; if (got.size() != 2) begin n_err++; $display("FAIL multi_first: got %0d events want 2", got.size()); end
      poll3(16'h0090, 3);
      n_cmp++; if (btn !== 16'h0090) begin n_err++; $display("FAIL multi_btn: got %h want 0090", btn); end
      got.delete();
      run_collect(25);
      n_cmp++; if (got.size() != 4) begin n_err++; $display("FAIL multi_size: got %0d want 4", got.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < got.size()) begin
            n_cmp++; if (got[i] !== exp[i]) begin
               n_err++; $display("FAIL multi_ev%0d: got %h want %h", i, got[i], exp[i]);
            end
         end
      end
   endtask

   task automatic test_overflow();
      do_reset();
      poll3(16'h0FFF, 1);
      repeat (20) tick();
      n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL ovf_count: got %0d want 8", count); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      n_cmp++; if (ev_data !== 5'h10) begin n_err++; $display("FAIL ovf_head: got %h want 10", ev_data); end
      ov_clr = 1'b1;
      tick();
      ov_clr = 1'b0;
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
   endtask

   // Continues from the full FIFO left by test_overflow.
   task automatic test_full_push_pop();
      poll3(16'h0FFE, 1);
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
      n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL fullpp_count: got %0d want 8", count); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpp_flag: got %b want 0", overflow); end
      n_cmp++; if (ev_data !== 5'h11) begin n_err++; $display("FAIL fullpp_head: got %h want 11", ev_data); end
      repeat (20) tick();
      got.delete();
      run_collect(20);
      n_cmp++; if (got.size() != 8) begin n_err++; $display("FAIL fullpp_drain: got %0d want 8", got.size()); end
      if (got.size() == 8) begin
         n_cmp++; if (got[7] !== 5'h00) begin n_err++; $display("FAIL fullpp_last: got %h want 00", got[7]); end
      end
   endtask

   initial begin
      test_reset();
      test_accept();
      test_reject();
      test_multibit();
      test_overflow();
      test_full_push_pop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
